m68k_bus_router: RTL and testbench
==================================

// Module: m68k_bus_router
// PURPOSE
// - Routes 68k bus requests to NTGT targets (boot ROM, SDRAM, I/O, ...), selected by top address bits.
// - Successor to the two-way boot/mem switch:
//   - parametrised target count and widths;
//   - registered request and response paths;
//   - per-target enable mask;
//   - bus-error timeout so that a dead target cannot hang the CPU.
// PARAMETERS
// AW       20       address width
// DW       16       data width
// SELBITS  2        number of top address bits used as target index; NTGT = 2**SELBITS
// TGT_EN   4'b1111  bit i = 1: target i is populated
// TIMEOUT  255      WAIT cycles before an error ack; 0 = never time out
// OPENBUS  16'hFFFF read data returned on an error ack
// PORTS
// clk       in   1         system clock
// rst       in   1         synchronous reset, active high
// m68kreq   in   1         CPU request; held until m68kack, dropped in the cycle after ack
// m68kaddr  in   AW        CPU address
// m68kwdata in   DW        CPU write data
// m68kwr    in   1         1 = write, 0 = read
// m68kack   out  1         one-cycle completion pulse
// m68kerr   out  1         qualifies m68kack: target disabled or timed out
// m68krdata out  DW        read data; valid only while m68kack = 1
// tgtreq    out  NTGT      one-hot, one-cycle request pulse to the selected target
// tgtaddr   out  AW        latched address, shared by all targets
// tgtwdata  out  DW        latched write data, shared by all targets
// tgtwr     out  1         latched write flag
// tgtack    in   NTGT      per-target ack; a target may ack no earlier than the cycle after its tgtreq pulse
// tgtrdata  in   NTGT*DW   per-target read data; slice i = [i*DW +: DW]; valid while tgtack[i] = 1
// BEHAVIOUR
// - All outputs are registered.
// - Reset: state = IDLE; m68kack, m68kerr, tgtreq, tgtwr = 0; m68krdata, tgtaddr, tgtwdata = 0; timeout counter = 0.
// - States: IDLE, WAIT, DONE. sel = m68kaddr[AW-1 -: SELBITS].
// - IDLE, m68kreq = 1 sampled at edge T:
//   - latch tgtaddr, tgtwdata, tgtwr and sel.
//   - TGT_EN[sel] = 1: tgtreq[sel] = 1 during cycle T+1 only; counter cleared; go to WAIT.
//   - TGT_EN[sel] = 0: no tgtreq; m68kack = m68kerr = 1 and m68krdata = OPENBUS during cycle T+1; go to DONE.
// - WAIT: the counter increments on every WAIT edge.
//   - tgtack[sel] sampled at edge E: m68kack = 1, m68kerr = 0, m68krdata = tgtrdata[sel] during cycle E+1; go to DONE.
//   - Otherwise, with TIMEOUT != 0 and the counter reaching TIMEOUT: error ack with OPENBUS; go to DONE.
//   - An ack and the timeout on the same edge: the ack wins, with no error.
//   - tgtack from unselected targets is ignored.
// - DONE: m68kack and m68kerr return to 0; unconditional move to IDLE; m68kreq is ignored in DONE.
//   - Minimum gap between two CPU transactions is therefore one idle cycle.
// - tgtaddr, tgtwdata and tgtwr stay stable from the tgtreq pulse until the next transaction latches.
// - Read latency with an ack in the first WAIT cycle: req sampled at T, tgtreq in T+1, ack sampled at T+2, m68kack in T+2..T+3 (registered).
// - A late tgtack arriving in IDLE or DONE is ignored and never produces a second m68kack.
// - Reset mid-transaction: immediate return to IDLE, all outputs cleared, no ack issued.
//   - A target ack pending from before reset is ignored.
// - Writes complete the same way as reads; m68krdata carries the target's slice but has no meaning.
// TESTING
// 1. Read: addr 20'h80010 (sel 2), target 2 acks 3 cycles after tgtreq with 16'hBEEF
//    -> single tgtreq[2] pulse; single m68kack with rdata BEEF, err 0.
// 2. Write: addr 20'h00004, wdata 16'h1234, wr = 1
//    -> tgtreq[0], tgtaddr = 00004, tgtwdata = 1234, tgtwr = 1; ack returned; err 0.
// 3. TGT_EN = 4'b0111, request to 20'hC0000 -> no tgtreq; ack one cycle after req, err 1, rdata FFFF.
// 4. TIMEOUT = 8, target never acks -> err ack after 8 WAIT cycles, rdata FFFF.
//    Target then acks late -> no extra m68kack.
// 5. TIMEOUT = 8, ack on the same edge as the timeout -> normal ack, err 0, target data returned.
// 6. Assert rst in WAIT, then target 1 acks -> no m68kack; all outputs 0.
//    Next request after reset completes normally.

Source files
------------

// File: rtl/m68k_bus_router.sv
// 68k bus router: decodes the top address bits into one of NTGT targets,
// forwards a registered one-cycle request and returns a registered ack.
// A disabled target or a target that stays silent for TIMEOUT wait cycles
// is answered with an error ack carrying OPENBUS read data.
module m68k_bus_router #(
  parameter int                         AW      = 20,
  parameter int                         DW      = 16,
  parameter int                         SELBITS = 2,
  parameter logic [(1<<SELBITS)-1:0]    TGT_EN  = 4'b1111,
  parameter int                         TIMEOUT = 255,
  parameter logic [DW-1:0]              OPENBUS = 16'hFFFF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          m68kreq,
  input  logic [AW-1:0]                 m68kaddr,
  input  logic [DW-1:0]                 m68kwdata,
  input  logic                          m68kwr,
  output logic                          m68kack,
  output logic                          m68kerr,
  output logic [DW-1:0]                 m68krdata,
  output logic [(1<<SELBITS)-1:0]       tgtreq,
  output logic [AW-1:0]                 tgtaddr,
  output logic [DW-1:0]                 tgtwdata,
  output logic                          tgtwr,
  input  logic [(1<<SELBITS)-1:0]       tgtack,
  input  logic [(1<<SELBITS)*DW-1:0]    tgtrdata
);

  localparam int NTGT = 1 << SELBITS;
  // Counter only needs to reach TIMEOUT-1; a zero TIMEOUT disables the check.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [SELBITS-1:0]   sel;
  logic [SELBITS-1:0]   sel_q;
  logic [CW-1:0]        cnt;
  logic [DW-1:0]        rd_slice [NTGT];

  assign sel = m68kaddr[AW-1 -: SELBITS];

  // Split the flat read-data bus into per-target slices for the return mux.
  for (genvar i = 0; i < NTGT; i++) begin : g_slice
    assign rd_slice[i] = tgtrdata[i*DW +: DW];
  end

  // Transaction FSM; every output is a register written only here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel_q     <= '0;
      cnt       <= '0;
      m68kack   <= 1'b0;
      m68kerr   <= 1'b0;
      m68krdata <= '0;
      tgtreq    <= '0;
      tgtaddr   <= '0;
      tgtwdata  <= '0;
      tgtwr     <= 1'b0;
    end else begin
      // Ack and request are single-cycle pulses by default.
      m68kack <= 1'b0;
      m68kerr <= 1'b0;
      tgtreq  <= '0;
      case (state)
        IDLE: begin
          if (m68kreq) begin
            tgtaddr  <= m68kaddr;
            tgtwdata <= m68kwdata;
            tgtwr    <= m68kwr;
            sel_q    <= sel;
            if (TGT_EN[sel]) begin
              tgtreq <= NTGT'(1) << sel;
              cnt    <= '0;
              state  <= WAIT;
            end else begin
              // Unpopulated slot: answer straight away with a bus error.
              m68kack   <= 1'b1;
              m68kerr   <= 1'b1;
              m68krdata <= OPENBUS;
              state     <= DONE;
            end
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          // Target ack takes priority over a timeout on the same edge.
          if (tgtack[sel_q]) begin
            m68kack   <= 1'b1;
            m68krdata <= rd_slice[sel_q];
            state     <= DONE;
          end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
            m68kack   <= 1'b1;
            m68kerr   <= 1'b1;
            m68krdata <= OPENBUS;
            state     <= DONE;
          end
        end
        DONE: begin
          // Held request from the finished cycle is deliberately ignored here.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m68k_bus_router.sv
// Scoreboarded random bench for m68k_bus_router with target 3 unpopulated
// and an 8-cycle timeout. A responder process models the targets.
module tb_m68k_bus_router;

  localparam int AW = 20, DW = 16, SELBITS = 2, NT = 4, TMO = 8;
  localparam logic [NT-1:0] EN = 4'b0111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m68kreq = 1'b0;
  logic [AW-1:0] m68kaddr = '0;
  logic [DW-1:0] m68kwdata = '0;
  logic m68kwr = 1'b0;
  logic m68kack, m68kerr;
  logic [DW-1:0] m68krdata;
  logic [NT-1:0] tgtreq;
  logic [AW-1:0] tgtaddr;
  logic [DW-1:0] tgtwdata;
  logic tgtwr;
  logic [NT-1:0] tgtack = '0;
  logic [NT*DW-1:0] tgtrdata = '0;

  m68k_bus_router #(.AW(AW), .DW(DW), .SELBITS(SELBITS), .TGT_EN(EN),
                    .TIMEOUT(TMO), .OPENBUS(16'hFFFF)) dut (
    .clk(clk), .rst(rst), .m68kreq(m68kreq), .m68kaddr(m68kaddr),
    .m68kwdata(m68kwdata), .m68kwr(m68kwr), .m68kack(m68kack),
    .m68kerr(m68kerr), .m68krdata(m68krdata), .tgtreq(tgtreq),
    .tgtaddr(tgtaddr), .tgtwdata(tgtwdata), .tgtwr(tgtwr),
    .tgtack(tgtack), .tgtrdata(tgtrdata));

  always #5 clk = ~clk;

  typedef struct { logic err; logic [DW-1:0] rdata; int rcyc; int lat; } exp_t;
  typedef struct { logic [NT-1:0] onehot; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic wr; } texp_t;

  exp_t  sbq [$];
  texp_t tq  [$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Current transaction's target behaviour, read by the responder.
  logic [SELBITS-1:0] cur_sel = '0;
  int cur_delay = 1;
  bit cur_noack = 1'b0;
  logic [DW-1:0] cur_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever @(posedge clk) cyc++;

  // Target responder: acks the selected target d cycles after its tgtreq
  // pulse, and toggles random acks/data on the other targets as noise.
  initial begin
    int cd = -1;
    logic [NT-1:0] av;
    logic [NT*DW-1:0] dv;
    forever begin
      @(negedge clk);
      av = '0;
      for (int j = 0; j < NT; j++) begin
        dv[j*DW +: DW] = DW'($urandom);
        if (j != int'(cur_sel) && $urandom_range(3) == 0) av[j] = 1'b1;
      end
      if (|tgtreq) cd = cur_noack ? -1 : cur_delay;
      else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          av[cur_sel] = 1'b1;
          dv[int'(cur_sel)*DW +: DW] = cur_data;
        end
      end
      tgtack = av;
      tgtrdata = dv;
    end
  end

  // CPU-side monitor: every ack must match the oldest outstanding expectation.
  initial forever begin
    @(negedge clk);
    if (m68kerr && !m68kack) chk("err_without_ack", 1, 0);
    if (m68kack) begin
      if (sbq.size() == 0) chk("unexpected_ack", 1, 0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("ack_err", m68kerr, e.err);
        chk("ack_rdata", m68krdata, e.rdata);
        chk("ack_latency", 64'(cyc - e.rcyc), 64'(e.lat));
      end
    end
  end

  // Target-side monitor: one tgtreq pulse per enabled transaction.
  initial forever begin
    @(negedge clk);
    if (|tgtreq) begin
      if (tq.size() == 0) chk("unexpected_tgtreq", 1, 0);
      else begin
        texp_t t;
        t = tq.pop_front();
        chk("tgtreq_onehot", tgtreq, t.onehot);
        chk("tgtaddr", tgtaddr, t.addr);
        chk("tgtwdata", tgtwdata, t.wdata);
        chk("tgtwr", tgtwr, t.wr);
      end
    end
  end

  // Issue one CPU transaction and push what the reference model predicts.
  task automatic do_txn(input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic wr,
                        input int d, input bit noack, input logic [DW-1:0] data);
    exp_t e;
    texp_t t;
    int s;
    bit ok;
    @(negedge clk);
    s = int'(a[AW-1 -: SELBITS]);
    cur_sel = a[AW-1 -: SELBITS];
    cur_delay = d;
    cur_noack = noack;
    cur_data = data;
    // Reference model: ack lands on wait edge d+1; the timeout hits edge TMO.
    ok = EN[s] && !noack && (d + 1 <= TMO);
    e.err   = !ok;
    e.rdata = ok ? data : 16'hFFFF;
    e.rcyc  = cyc + 1;
    e.lat   = !EN[s] ? 0 : (ok ? d + 1 : TMO);
    sbq.push_back(e);
    if (EN[s]) begin
      t.onehot = NT'(1 << s);
      t.addr = a; t.wdata = wd; t.wr = wr;
      tq.push_back(t);
    end
    m68kreq = 1'b1; m68kaddr = a; m68kwdata = wd; m68kwr = wr;
    begin : wait_ack
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (m68kack) disable wait_ack;
      end
      chk("ack_timeout_bound", 1, 0);
    end
    m68kreq = 1'b0;
    m68kaddr = AW'($urandom);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {m68kack, m68kerr, tgtreq, tgtwr, m68krdata, tgtaddr, tgtwdata}, 0);
    rst = 1'b0;

    do_txn(20'h80010, 16'h0000, 1'b0, 3, 1'b0, 16'hBEEF);   // read from target 2
    do_txn(20'h00004, 16'h1234, 1'b1, 2, 1'b0, 16'h5A5A);   // write to target 0
    do_txn(20'hC0000, 16'h0000, 1'b0, 1, 1'b0, 16'h1111);   // disabled target 3
    do_txn(20'h40000, 16'h0000, 1'b0, 8, 1'b0, 16'h2222);   // timeout, late ack
    repeat (3) @(negedge clk);
    do_txn(20'h40100, 16'h0000, 1'b0, 7, 1'b0, 16'h3333);   // ack on timeout edge
    do_txn(20'h80200, 16'h0000, 1'b0, 1, 1'b1, 16'h4444);   // never acks

    // Reset while waiting on target 1, whose ack then arrives after reset.
    @(negedge clk);
    cur_sel = 2'd1; cur_delay = 5; cur_noack = 1'b0; cur_data = 16'h7777;
    tq.push_back('{onehot: 4'b0010, addr: 20'h40020, wdata: 16'hAAAA, wr: 1'b0});
    m68kreq = 1'b1; m68kaddr = 20'h40020; m68kwdata = 16'hAAAA; m68kwr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1; m68kreq = 1'b0;
    @(negedge clk);
    chk("midtxn_reset_outputs", {m68kack, m68kerr, tgtreq, tgtwr, m68krdata, tgtaddr, tgtwdata}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_reset_quiet", {m68kack, m68kerr, tgtreq, m68krdata}, 0);
    do_txn(20'h40030, 16'h0000, 1'b0, 2, 1'b0, 16'hC0DE);

    for (int n = 0; n < 150; n++) begin
      logic [AW-1:0] a;
      a = AW'($urandom);
      do_txn(a, DW'($urandom), 1'($urandom), int'($urandom_range(8, 1)),
             ($urandom_range(7) == 0), DW'($urandom));
      repeat ($urandom_range(2)) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    chk("sb_drained", 64'(sbq.size()), 0);
    chk("tq_drained", 64'(tq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
